// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one byte by driving open-drain enables. Optional PS2_TX_RETRY_EN adds one re-send on NACK/timeout.
// Latency: INHIBIT_CYCLES+2 cycles, then 11 device clocks plus a 3-flop sync delay to done.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic [2:0]    clk_s, data_s;
    logic [IW-1:0] inh_cnt, inh_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [9:0]    frame, frame_n;
    logic          clk_oe_n, data_oe_n, done_n, ack_err_n, timeout_n;
    logic          fall, lines_idle, to_hit, accept;
    logic          abort, finish, restart, can_retry;

    assign fall       = clk_s[2] & ~clk_s[1];
    assign lines_idle = clk_s[1] & data_s[1];
    assign to_hit     = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign tx_ready   = (state == IDLE);
    assign accept     = tx_ready & tx_valid;

`ifdef PS2_TX_RETRY_EN
    logic retried;

    always_ff @(posedge clk) begin
        if (!clrn)        retried <= 1'b0;
        else if (accept)  retried <= 1'b0;
        else if (restart) retried <= 1'b1;
    end

    assign can_retry = ~retried;
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_s  <= 3'b111;
            data_s <= 3'b111;
        end else begin
            clk_s  <= {clk_s[1:0], ps2_clk};
            data_s <= {data_s[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= IDLE;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_idx     <= '0;
            frame       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            inh_cnt     <= inh_cnt_n;
            to_cnt      <= to_cnt_n;
            bit_idx     <= bit_idx_n;
            frame       <= frame_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done        <= done_n;
            ack_err     <= ack_err_n;
            timeout     <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        inh_cnt_n = inh_cnt;
        to_cnt_n  = to_cnt;
        bit_idx_n = bit_idx;
        frame_n   = frame;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        ack_err_n = ack_err;
        done_n    = 1'b0;
        timeout_n = 1'b0;
        abort     = 1'b0;
        finish    = 1'b0;
        restart   = 1'b0;

        if (state == SEND || state == ACK || state == WAIT_IDLE)
            to_cnt_n = fall ? '0 : to_cnt + 1'b1;

        case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    // frame = stop, odd parity, data (LSB sent first)
                    frame_n   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_n = '0;
                    ack_err_n = 1'b0;
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_cnt_n = inh_cnt + 1'b1;
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_n = 1'b1;
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                clk_oe_n  = 1'b0;
                bit_idx_n = '0;
                to_cnt_n  = '0;
                state_n   = SEND;
            end
            SEND: begin
                if (fall) begin
                    data_oe_n = ~frame[bit_idx];
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx == 4'd9)
                        state_n = ACK;
                end else if (to_hit) begin
                    abort = 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    ack_err_n = data_s[1];
                    state_n   = WAIT_IDLE;
                end else if (to_hit) begin
                    abort = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (lines_idle)
                    finish = 1'b1;
                else if (!fall && to_hit)
                    abort = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (abort) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (can_retry) begin
                restart = 1'b1;
            end else begin
                timeout_n = 1'b1;
                state_n   = IDLE;
            end
        end

        if (finish) begin
            if (ack_err && can_retry) begin
                restart = 1'b1;
            end else begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end

        // The latched frame is kept intact, so a re-send just re-enters INHIBIT.
        if (restart) begin
            inh_cnt_n = '0;
            clk_oe_n  = 1'b1;
            data_oe_n = 1'b0;
            state_n   = INHIBIT;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT, and the sampled bits are checked against an
// arithmetic frame/parity model. Covers reset, NACK, timeout, reset mid-frame, and tx_valid held across a frame.
module tb_ps2_host_tx;
    localparam int INH   = 16;
    localparam int TO    = 200;
    localparam int BOUND = INH + TO + 600;
    // pin edge -> 3 synchronizer stages -> registered event, observed at the following negedge
    localparam int PIN_LAT = 4;
`ifdef PS2_TX_RETRY_EN
    localparam int TRIES = 2;
`else
    localparam int TRIES = 1;
`endif

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, done, ack_err, timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk  = ~ps2_clk_oe & dev_clk;
    assign ps2_data = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc = 0, done_cnt = 0, to_cnt = 0, acc_cnt = 0, to_cyc = 0;
    logic done_ack = 1'b0, to_clk_oe = 1'b1, to_data_oe = 1'b1, to_ready = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_ack = ack_err;
        end
        if (timeout) begin
            to_cnt++;
            to_cyc     = cyc;
            to_clk_oe  = ps2_clk_oe;
            to_data_oe = ps2_data_oe;
            to_ready   = tx_ready;
        end
        if (clrn && tx_valid && tx_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start bit 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic submit(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < BOUND) begin @(posedge clk); #1; n++; end
        check("tx_ready", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Device side: wait for request-to-send, then issue nfalls clock pulses, sampling data on each rise.
    task automatic dev_frame(input int nfalls, input bit ack_low, input int h,
                             output logic [10:0] bits, output int inh, output int lf);
        int n;
        n = 0; inh = 0; lf = cyc; bits = '1;
        dev_clk = 1'b1; dev_data = 1'b1;
        while (!ps2_clk_oe && n < BOUND) begin @(posedge clk); #1; n++; end
        check("rts_clk", ps2_clk_oe, 1);
        while (ps2_clk_oe && inh < BOUND) begin @(posedge clk); #1; inh++; end
        check("rts_data", ps2_data_oe, 1);
        bits[0] = ps2_data;
        for (int i = 0; i < nfalls; i++) begin
            repeat (h) @(posedge clk);
            #1;
            dev_clk = 1'b0;
            lf = cyc;
            repeat (h) @(posedge clk);
            #1;
            if (i < 10) bits[i+1] = ps2_data;
            dev_clk = 1'b1;
            if (i == 9)  dev_data = ~ack_low;
            if (i == 10) dev_data = 1'b1;
        end
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < BOUND) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        check("done_cnt", done_cnt, target);
    endtask

    task automatic run_byte(input logic [7:0] b, input bit ack_low, input int h);
        logic [10:0] bits;
        int inh, lf, d0, tries;
        d0 = done_cnt;
        tries = ack_low ? 1 : TRIES;
        submit(b);
        for (int a = 0; a < tries; a++) begin
            dev_frame(11, ack_low, h, bits, inh, lf);
            check("frame", bits, exp_frame(b));
            check("inhibit_len", inh, INH + 1);
        end
        wait_done(d0 + 1);
        check("ack_err", done_ack, !ack_low);
    endtask

    initial begin
        logic [10:0] bits, ef;
        logic [7:0]  b, b2;
        int inh, lf, d0, t0, acc0, n, h;

        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        check("rst_ready", tx_ready, 1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_timeout", timeout, 0);

        run_byte(8'hED, 1'b1, 8);
        run_byte(8'h01, 1'b1, 6);
        run_byte(8'hFF, 1'b1, 9);
        run_byte(8'h00, 1'b1, 5);
        run_byte(8'hF4, 1'b0, 7);

        for (int k = 0; k < 10; k++)
            run_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, int'($urandom_range(5, 12)));

        // device stops clocking after bit 3
        d0 = done_cnt; t0 = to_cnt;
        b  = 8'($urandom_range(0, 255));
        ef = exp_frame(b);
        h  = int'($urandom_range(5, 10));
        submit(b);
        for (int a = 0; a < TRIES; a++) begin
            dev_frame(4, 1'b1, h, bits, inh, lf);
            check("to_partial", bits[4:0], ef[4:0]);
        end
        n = 0;
        while (to_cnt == t0 && n < BOUND) begin @(posedge clk); #1; n++; end
        check("to_pulse", to_cnt, t0 + 1);
        check("to_delay", to_cyc - lf, TO + PIN_LAT);
        check("to_clk_oe", to_clk_oe, 0);
        check("to_data_oe", to_data_oe, 0);
        check("to_ready", to_ready, 1);
        check("to_no_done", done_cnt, d0);

        // reset while b1 (=0) of 0xED is being driven
        d0 = done_cnt; t0 = to_cnt;
        submit(8'hED);
        dev_frame(2, 1'b1, 6, bits, inh, lf);
        check("pre_rst_data_oe", ps2_data_oe, 1);
        @(posedge clk); #1;
        clrn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        clrn = 1'b1;
        repeat (TO + 20) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_no_to", to_cnt, t0);
        run_byte(8'hED, 1'b1, 7);

        // tx_valid held high across a whole frame
        acc0 = acc_cnt; d0 = done_cnt;
        b  = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        h  = int'($urandom_range(5, 10));
        @(posedge clk); #1;
        tx_data = b; tx_valid = 1'b1;
        dev_frame(11, 1'b1, h, bits, inh, lf);
        check("held_frame1", bits, exp_frame(b));
        check("held_acc1", acc_cnt - acc0, 1);
        n = 0;
        while (!done && n < BOUND) begin @(posedge clk); #1; n++; end
        check("held_done", done, 1);
        tx_data = b2;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("held_acc2", acc_cnt - acc0, 2);
        dev_frame(11, 1'b1, h, bits, inh, lf);
        check("held_frame2", bits, exp_frame(b2));
        check("held_inhibit", inh, INH + 1);
        wait_done(d0 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
